sha3_round_sequencer: RTL

Drives a single iterable SHA3 round unit through all Keccak-f[1600] rounds for one state at a time. It accepts a 25-lane state, issues round indices 0..ROUNDS-1 to the round unit with one `sample` strobe per round, and feeds each round result back as the next round's input. After the last round it presents the permuted state on a valid/ready output. It sits between the nonce/message front-end and the iterable round core. It is the initiator of the round unit's sample/round_index/ogood protocol.

---
 rtl/sha3_round_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sha3_round_sequencer.sv
// Round sequencer for an iterable Keccak-f[1600] round unit: takes one
// 25-lane state, issues rounds 0..ROUNDS-1 with a sample strobe each,
// feeds every round result back in and presents the permuted state on a
// valid/ready output. Lane x of row y lives in s<row>[x] (sa = row 0).
module sha3_round_sequencer #(
    parameter int unsigned ROUNDS = 24
) (
    input  logic             clk,
    input  logic             rst_n,

    // Upstream state input
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0][63:0] isa,
    input  logic [4:0][63:0] isb,
    input  logic [4:0][63:0] isc,
    input  logic [4:0][63:0] isd,
    input  logic [4:0][63:0] ise,

    // Round unit request side
    output logic [4:0]       rnd_index,
    output logic             rnd_sample,
    output logic [4:0][63:0] rnd_sa,
    output logic [4:0][63:0] rnd_sb,
    output logic [4:0][63:0] rnd_sc,
    output logic [4:0][63:0] rnd_sd,
    output logic [4:0][63:0] rnd_se,

    // Round unit result side
    input  logic [4:0][63:0] rnd_osa,
    input  logic [4:0][63:0] rnd_osb,
    input  logic [4:0][63:0] rnd_osc,
    input  logic [4:0][63:0] rnd_osd,
    input  logic [4:0][63:0] rnd_ose,
    input  logic [4:0]       rnd_oround,
    input  logic             rnd_ogood,

    // Permuted state output
    output logic [4:0][63:0] osa,
    output logic [4:0][63:0] osb,
    output logic [4:0][63:0] osc,
    output logic [4:0][63:0] osd,
    output logic [4:0][63:0] ose,
    output logic             ovalid,
    input  logic             oready,

    output logic             err
);

    localparam logic [4:0] LastRound = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            load_in;
    logic            load_rnd;

    logic [4:0][63:0] sa_q, sb_q, sc_q, sd_q, se_q;

    // FSM, round counter and sticky error register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, handshake strobes and error detection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        load_in    = 1'b0;
        load_rnd   = 1'b0;
        in_ready   = 1'b0;
        rnd_sample = 1'b0;
        ovalid     = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (rnd_ogood) begin
                    err_d = 1'b1;
                end
                if (in_valid) begin
                    load_in = 1'b1;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                rnd_sample = 1'b1;
                if (rnd_ogood) begin
                    err_d = 1'b1;
                end
                state_d = StWait;
            end
            StWait: begin
                if (rnd_ogood) begin
                    // A mislabelled result is flagged but still taken
                    load_rnd = 1'b1;
                    if (rnd_oround != cnt_q) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == LastRound) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                ovalid = 1'b1;
                if (rnd_ogood) begin
                    err_d = 1'b1;
                end
                if (oready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register: loaded from upstream on accept, from the round unit
    // on each accepted round result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q <= '0;
            sb_q <= '0;
            sc_q <= '0;
            sd_q <= '0;
            se_q <= '0;
        end else if (load_in) begin
            sa_q <= isa;
            sb_q <= isb;
            sc_q <= isc;
            sd_q <= isd;
            se_q <= ise;
        end else if (load_rnd) begin
            sa_q <= rnd_osa;
            sb_q <= rnd_osb;
            sc_q <= rnd_osc;
            sd_q <= rnd_osd;
            se_q <= rnd_ose;
        end
    end

    assign rnd_index = cnt_q;
    assign rnd_sa    = sa_q;
    assign rnd_sb    = sb_q;
    assign rnd_sc    = sc_q;
    assign rnd_sd    = sd_q;
    assign rnd_se    = se_q;

    assign osa = sa_q;
    assign osb = sb_q;
    assign osc = sc_q;
    assign osd = sd_q;
    assign ose = se_q;

    assign err = err_q;

endmodule
